// File: rtl/status_snap_pkg.sv
// Shared definitions for the WireOut status snapshot block:
// the snapshot FSM state encoding, the shadow word bit map,
// and helpers that assemble the two words carrying the snapshot sequence number.
package status_snap_pkg;

  localparam int SEQ_W     = 8;

  // Bit positions shared by word1 and word3
  localparam int SEQ_H     = 31;
  localparam int SEQ_L     = 24;

  // Bit positions in word3
  localparam int FLAG_OVR  = 18;
  localparam int FLAG_SAT  = 17;
  localparam int FLAG_WRAP = 16;
  localparam int ERR_H     = 15;
  localparam int ERR_L     = 0;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SAMPLE = 2'd1,
    ST_COMMIT = 2'd2
  } snap_state_t;

  // word1 = {seq, 8'h00, event_cnt[47:32]}
  function automatic logic [31:0] pack_word1(input logic [SEQ_W-1:0] seq,
                                             input logic [15:0]      evt_hi);
    logic [31:0] w;
    w              = '0;
    w[SEQ_H:SEQ_L] = seq;
    w[15:0]        = evt_hi;
    return w;
  endfunction

  // word3 = {seq, 5'b0, snap_ovr, err_sat, evt_wrap, err_cnt}
  function automatic logic [31:0] pack_word3(input logic [SEQ_W-1:0] seq,
                                             input logic             ovr,
                                             input logic             sat,
                                             input logic             wrap,
                                             input logic [15:0]      err);
    logic [31:0] w;
    w              = '0;
    w[SEQ_H:SEQ_L] = seq;
    w[FLAG_OVR]    = ovr;
    w[FLAG_SAT]    = sat;
    w[FLAG_WRAP]   = wrap;
    w[ERR_H:ERR_L] = err;
    return w;
  endfunction

endpackage

// File: rtl/status_counter.sv
// Purpose: W-bit strobe counter, wrapping or saturating, with sticky wrap/saturate flag.
// Latency: count updates on the edge that samples the strobe; nxt is the combinational live+strobe value.
// Backpressure: none, every strobe is counted. Ports: ti_clk, ti_reset_n, strobe, load, load_strobe, clr_flag -> nxt, flag.
module status_counter #(
  parameter int W   = 16,
  parameter bit SAT = 1'b0
) (
  input  logic         ti_clk,
  input  logic         ti_reset_n,
  input  logic         strobe,       // one-cycle increment request
  input  logic         load,         // restart the count
  input  logic         load_strobe,  // on load, restart at strobe (1) instead of 0
  input  logic         clr_flag,     // clear the sticky flag
  output logic [W-1:0] nxt,          // count including this cycle's strobe
  output logic         flag          // sticky: wrapped (SAT=0) or reached all-ones (SAT=1)
);

  // One below all-ones: the value from which a strobe saturates the counter.
  localparam logic [W-1:0] ALMOST = ~W'(1);

  logic [W-1:0] cnt_q;
  logic         hit;

  always_comb begin
    nxt = cnt_q + W'(strobe);
    hit = strobe & (&cnt_q);
    if (SAT) begin
      if (&cnt_q) begin
        nxt = cnt_q;
      end
      hit = strobe & (cnt_q == ALMOST);
    end
  end

  always_ff @(posedge ti_clk) begin
    if (!ti_reset_n) begin
      cnt_q <= '0;
      flag  <= 1'b0;
    end else begin
      cnt_q <= load ? W'(strobe & load_strobe) : nxt;
      // A wrap/saturate seen in the same cycle as a clear belongs to the
      // discarded data, so the clear wins.
      flag  <= clr_flag ? 1'b0 : (flag | hit);
    end
  end

endmodule

// File: rtl/wireout_status_snapshot.sv
// Purpose: live imager event/frame/error counters with an atomic snapshot into four WireOut shadow words.
// Latency: snap_req sampled at edge N -> ep_datain0..3 and snap_valid updated after edge N+2.
// Backpressure: none; snap_req while busy is dropped and reported via sticky snap_ovr in word3.
// Ports: ti_clk/ti_reset_n; strobes ev_pulse, frame_start, err_pulse; snap_req, clr_req, cfg_clr_on_snap;
//        outputs ep_datain0..3 (shadow words), snap_valid (one-cycle update pulse), busy (capture in progress).
module wireout_status_snapshot
  import status_snap_pkg::*;
#(
  parameter int EVT_W = 48,
  parameter int FRM_W = 32,
  parameter int ERR_W = 16
) (
  input  logic        ti_clk,
  input  logic        ti_reset_n,
  input  logic        ev_pulse,
  input  logic        frame_start,
  input  logic        err_pulse,
  input  logic        snap_req,
  input  logic        clr_req,
  input  logic        cfg_clr_on_snap,
  output logic [31:0] ep_datain0,
  output logic [31:0] ep_datain1,
  output logic [31:0] ep_datain2,
  output logic [31:0] ep_datain3,
  output logic        snap_valid,
  output logic        busy
);

  snap_state_t      state;
  logic             accept;
  logic             cnt_load;
  logic             load_strobe;

  logic [EVT_W-1:0] evt_nxt, evt_stage;
  logic [FRM_W-1:0] frm_nxt, frm_stage;
  logic [ERR_W-1:0] err_nxt, err_stage;
  logic             evt_wrap, err_sat, frm_wrap_unused;
  logic             snap_ovr;
  logic [SEQ_W-1:0] snap_seq, seq_next;
  logic [47:0]      evt_stage48;

  assign accept      = snap_req & (state == ST_IDLE);
  assign cnt_load    = clr_req | (accept & cfg_clr_on_snap);
  // A strobe arriving with an accepted snapshot is already inside the stage
  // value, so the live count restarts at 0 to avoid counting it twice.
  // A plain clear keeps the strobe so it is not lost.
  assign load_strobe = ~accept;

  assign seq_next    = snap_seq + SEQ_W'(1);
  assign evt_stage48 = 48'(evt_stage);

  status_counter #(.W(EVT_W), .SAT(1'b0)) u_evt (
    .ti_clk      (ti_clk),
    .ti_reset_n  (ti_reset_n),
    .strobe      (ev_pulse),
    .load        (cnt_load),
    .load_strobe (load_strobe),
    .clr_flag    (clr_req),
    .nxt         (evt_nxt),
    .flag        (evt_wrap)
  );

  status_counter #(.W(FRM_W), .SAT(1'b0)) u_frm (
    .ti_clk      (ti_clk),
    .ti_reset_n  (ti_reset_n),
    .strobe      (frame_start),
    .load        (cnt_load),
    .load_strobe (load_strobe),
    .clr_flag    (clr_req),
    .nxt         (frm_nxt),
    .flag        (frm_wrap_unused)
  );

  status_counter #(.W(ERR_W), .SAT(1'b1)) u_err (
    .ti_clk      (ti_clk),
    .ti_reset_n  (ti_reset_n),
    .strobe      (err_pulse),
    .load        (cnt_load),
    .load_strobe (load_strobe),
    .clr_flag    (clr_req),
    .nxt         (err_nxt),
    .flag        (err_sat)
  );

  always_ff @(posedge ti_clk) begin
    if (!ti_reset_n) begin
      state      <= ST_IDLE;
      busy       <= 1'b0;
      snap_valid <= 1'b0;
      evt_stage  <= '0;
      frm_stage  <= '0;
      err_stage  <= '0;
      snap_seq   <= '0;
      snap_ovr   <= 1'b0;
      ep_datain0 <= '0;
      ep_datain1 <= '0;
      ep_datain2 <= '0;
      ep_datain3 <= '0;
    end else begin
      snap_valid <= 1'b0;

      case (state)
        ST_IDLE: begin
          if (snap_req) begin
            evt_stage <= evt_nxt;
            frm_stage <= frm_nxt;
            err_stage <= err_nxt;
            state     <= ST_SAMPLE;
            busy      <= 1'b1;
          end
        end
        ST_SAMPLE: begin
          state <= ST_COMMIT;
        end
        ST_COMMIT: begin
          // Flags are taken as they stand now, so anything that happened
          // while the capture was in flight is reported with it.
          ep_datain0 <= evt_stage48[31:0];
          ep_datain1 <= pack_word1(seq_next, evt_stage48[47:32]);
          ep_datain2 <= 32'(frm_stage);
          ep_datain3 <= pack_word3(seq_next, snap_ovr, err_sat, evt_wrap, 16'(err_stage));
          snap_seq   <= seq_next;
          snap_valid <= 1'b1;
          state      <= ST_IDLE;
          busy       <= 1'b0;
        end
        default: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
        end
      endcase

      if (clr_req) begin
        snap_ovr <= 1'b0;
      end else if (snap_req && (state != ST_IDLE)) begin
        snap_ovr <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_wireout_status_snapshot.sv
// Bench for wireout_status_snapshot: a cycle model of the counters and snapshot
// FSM pushes expected shadow words on commit; a monitor pops them on snap_valid.
// Directed checks with literal values cover latency, reset and corner cases.
module tb_wireout_status_snapshot;

  logic        ti_clk = 1'b0;
  logic        ti_reset_n;
  logic        ev_pulse, frame_start, err_pulse, snap_req, clr_req, cfg_clr_on_snap;
  logic [31:0] ep_datain0, ep_datain1, ep_datain2, ep_datain3;
  logic        snap_valid, busy;

  always #5 ti_clk = ~ti_clk;

  wireout_status_snapshot dut (
    .ti_clk          (ti_clk),
    .ti_reset_n      (ti_reset_n),
    .ev_pulse        (ev_pulse),
    .frame_start     (frame_start),
    .err_pulse       (err_pulse),
    .snap_req        (snap_req),
    .clr_req         (clr_req),
    .cfg_clr_on_snap (cfg_clr_on_snap),
    .ep_datain0      (ep_datain0),
    .ep_datain1      (ep_datain1),
    .ep_datain2      (ep_datain2),
    .ep_datain3      (ep_datain3),
    .snap_valid      (snap_valid),
    .busy            (busy)
  );

  typedef struct {
    logic [31:0] w0, w1, w2, w3;
  } snap_t;

  snap_t sb_q[$];
  snap_t mon_e;

  int n_total = 0;
  int n_bad   = 0;
  int n_valid = 0;

  // reference model state
  logic [47:0] m_e, s_e;
  logic [31:0] m_f, s_f;
  logic [15:0] m_r, s_r;
  logic        m_wrap, m_sat, m_ovr;
  logic [7:0]  m_seq;
  int          m_state;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_e = '0; m_f = '0; m_r = '0;
    s_e = '0; s_f = '0; s_r = '0;
    m_wrap = 1'b0; m_sat = 1'b0; m_ovr = 1'b0;
    m_seq = '0; m_state = 0;
  endtask

  // Advance the model by one clock edge with the given input values.
  task automatic model_edge(input logic ev, input logic fr, input logic er,
                            input logic snap, input logic clr);
    logic        acc, wrap_hit, sat_hit, restart;
    logic [47:0] ne;
    logic [31:0] nf;
    logic [15:0] nr;
    snap_t       e;
    acc      = snap && (m_state == 0);
    ne       = m_e + 48'(ev);
    nf       = m_f + 32'(fr);
    nr       = (m_r == 16'hFFFF) ? m_r : m_r + 16'(er);
    wrap_hit = ev && (m_e == 48'hFFFF_FFFF_FFFF);
    sat_hit  = er && (m_r == 16'hFFFE);
    if (m_state == 2) begin
      m_seq = m_seq + 8'd1;
      e.w0 = s_e[31:0];
      e.w1 = {m_seq, 8'h00, s_e[47:32]};
      e.w2 = s_f;
      e.w3 = {m_seq, 5'b0, m_ovr, m_sat, m_wrap, s_r};
      sb_q.push_back(e);
    end
    if (acc) begin
      s_e = ne; s_f = nf; s_r = nr;
    end
    if (clr) begin
      m_wrap = 1'b0; m_sat = 1'b0; m_ovr = 1'b0;
    end else begin
      m_wrap = m_wrap | wrap_hit;
      m_sat  = m_sat | sat_hit;
      if (snap && m_state != 0) m_ovr = 1'b1;
    end
    restart = clr || (acc && cfg_clr_on_snap);
    if (restart) begin
      m_e = acc ? 48'd0 : 48'(ev);
      m_f = acc ? 32'd0 : 32'(fr);
      m_r = acc ? 16'd0 : 16'(er);
    end else begin
      m_e = ne; m_f = nf; m_r = nr;
    end
    case (m_state)
      0:       m_state = acc ? 1 : 0;
      1:       m_state = 2;
      default: m_state = 0;
    endcase
  endtask

  task automatic step(input logic ev, input logic fr, input logic er,
                      input logic snap, input logic clr);
    ev_pulse = ev; frame_start = fr; err_pulse = er; snap_req = snap; clr_req = clr;
    model_edge(ev, fr, er, snap, clr);
    @(posedge ti_clk); #1;
    ev_pulse = 0; frame_start = 0; err_pulse = 0; snap_req = 0; clr_req = 0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0);
  endtask

  task automatic reset_dut();
    ti_reset_n = 1'b0;
    model_reset();
    repeat (2) @(posedge ti_clk);
    #1;
    ti_reset_n = 1'b1;
  endtask

  task automatic snap_and_wait();
    step(0, 0, 0, 1, 0);
    idle(3);
  endtask

  // scoreboard monitor
  always @(negedge ti_clk) begin
    if (snap_valid === 1'b1) begin
      n_valid++;
      if (sb_q.size() == 0) begin
        chk("sb_unexpected_valid", 32'(snap_valid), 32'd0);
      end else begin
        mon_e = sb_q.pop_front();
        chk("sb_word0", ep_datain0, mon_e.w0);
        chk("sb_word1", ep_datain1, mon_e.w1);
        chk("sb_word2", ep_datain2, mon_e.w2);
        chk("sb_word3", ep_datain3, mon_e.w3);
      end
    end
  end

  int v0;

  initial begin
    ti_reset_n = 1'b0;
    ev_pulse = 0; frame_start = 0; err_pulse = 0;
    snap_req = 0; clr_req = 0; cfg_clr_on_snap = 0;
    model_reset();

    // 1. reset with an event strobe held during reset
    ev_pulse = 1;
    repeat (3) @(posedge ti_clk);
    #1;
    ev_pulse = 0;
    chk("rst_word0", ep_datain0, 32'd0);
    chk("rst_word1", ep_datain1, 32'd0);
    chk("rst_word2", ep_datain2, 32'd0);
    chk("rst_word3", ep_datain3, 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_valid", 32'(snap_valid), 32'd0);
    ti_reset_n = 1'b1;
    model_reset();
    snap_and_wait();
    chk("rst_snap_word0", ep_datain0, 32'd0);
    chk("rst_snap_seq", 32'(ep_datain3[31:24]), 32'd1);

    // 2. basic snapshot, latency, back-to-back request after COMMIT
    reset_dut();
    for (int i = 0; i < 5; i++) step(1, 0, 0, 0, 0);
    for (int i = 0; i < 2; i++) step(0, 1, 0, 0, 0);
    step(0, 0, 1, 0, 0);
    v0 = n_valid;
    step(0, 0, 0, 1, 0);
    chk("lat_busy_sample", 32'(busy), 32'd1);
    chk("lat_valid_sample", 32'(snap_valid), 32'd0);
    step(0, 0, 0, 0, 0);
    chk("lat_busy_commit", 32'(busy), 32'd1);
    chk("lat_valid_commit", 32'(snap_valid), 32'd0);
    step(0, 0, 0, 0, 0);
    chk("lat_busy_done", 32'(busy), 32'd0);
    chk("lat_valid_done", 32'(snap_valid), 32'd1);
    chk("basic_word0", ep_datain0, 32'd5);
    chk("basic_word2", ep_datain2, 32'd2);
    chk("basic_err", 32'(ep_datain3[15:0]), 32'd1);
    chk("basic_seq", 32'(ep_datain3[31:24]), 32'd1);
    step(0, 0, 0, 1, 0);
    idle(3);
    chk("b2b_valid_count", 32'(n_valid - v0), 32'd2);
    chk("b2b_seq", 32'(ep_datain1[31:24]), 32'd2);

    // 3. same-cycle strobe with restart-on-snapshot
    reset_dut();
    cfg_clr_on_snap = 1;
    for (int i = 0; i < 9; i++) step(1, 0, 0, 0, 0);
    step(1, 0, 0, 1, 0);
    idle(3);
    chk("samecyc_word0", ep_datain0, 32'd10);
    snap_and_wait();
    chk("samecyc_next_word0", ep_datain0, 32'd0);
    cfg_clr_on_snap = 0;

    // 4. overrun
    reset_dut();
    for (int i = 0; i < 3; i++) step(1, 0, 0, 0, 0);
    v0 = n_valid;
    step(0, 0, 0, 1, 0);
    step(0, 0, 0, 1, 0);
    idle(3);
    chk("ovr_valid_count", 32'(n_valid - v0), 32'd1);
    chk("ovr_seq", 32'(ep_datain3[31:24]), 32'd1);
    snap_and_wait();
    chk("ovr_flag", 32'(ep_datain3[18]), 32'd1);
    chk("ovr_seq2", 32'(ep_datain3[31:24]), 32'd2);

    // 5a. error saturation
    reset_dut();
    for (int i = 0; i < 65540; i++) step(0, 0, 1, 0, 0);
    snap_and_wait();
    chk("sat_err", 32'(ep_datain3[15:0]), 32'h0000_FFFF);
    chk("sat_flag", 32'(ep_datain3[17]), 32'd1);
    chk("sat_no_wrap", 32'(ep_datain3[16]), 32'd0);

    // 5b. event counter wrap from all-ones
    reset_dut();
    force dut.u_evt.cnt_q = 48'hFFFF_FFFF_FFFF;
    @(posedge ti_clk); #1;
    release dut.u_evt.cnt_q;
    m_e = 48'hFFFF_FFFF_FFFF;
    step(1, 0, 0, 0, 0);
    snap_and_wait();
    chk("wrap_word0", ep_datain0, 32'd0);
    chk("wrap_word1_lo", 32'(ep_datain1[15:0]), 32'd0);
    chk("wrap_flag", 32'(ep_datain3[16]), 32'd1);

    // 6a. clear together with snapshot
    reset_dut();
    for (int i = 0; i < 4; i++) step(1, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) step(0, 1, 0, 0, 0);
    for (int i = 0; i < 2; i++) step(0, 0, 1, 0, 0);
    step(0, 0, 0, 1, 1);
    idle(3);
    chk("clr_word0", ep_datain0, 32'd4);
    chk("clr_word2", ep_datain2, 32'd3);
    chk("clr_err", 32'(ep_datain3[15:0]), 32'd2);
    snap_and_wait();
    chk("clr_after_word0", ep_datain0, 32'd0);
    chk("clr_after_word2", ep_datain2, 32'd0);
    chk("clr_after_err", 32'(ep_datain3[15:0]), 32'd0);

    // 6b. reset while in SAMPLE
    reset_dut();
    step(1, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0);
    v0 = n_valid;
    step(0, 0, 0, 1, 0);
    ti_reset_n = 1'b0;
    model_reset();
    @(posedge ti_clk); #1;
    ti_reset_n = 1'b1;
    idle(4);
    chk("rstmid_valid_count", 32'(n_valid - v0), 32'd0);
    chk("rstmid_word0", ep_datain0, 32'd0);
    chk("rstmid_word1", ep_datain1, 32'd0);
    chk("rstmid_word3", ep_datain3, 32'd0);
    chk("rstmid_busy", 32'(busy), 32'd0);

    idle(2);
    chk("sb_drained", 32'(sb_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
